c17_bist_tpg: RTL and testbench

Built-in self-test pattern generator driving the 5 primary inputs (G1..G5) of the c17 combinational circuit under test.
- Two modes: maximal-length LFSR pseudo-random sequence, or exhaustive binary count.
- Patterns are offered to the downstream capture/response stage over a valid/ready handshake.
- A start/done FSM bounds each test session.

---
 rtl/bist_pkg.sv | 17 +
 rtl/bist_lfsr.sv | 37 +++
 rtl/c17_bist_tpg.sv | 109 ++++++++++
 tb/tb_c17_bist_tpg.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST pattern generator and the response MISR.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_LFSR = 1'b0;
    localparam logic MODE_EXH  = 1'b1;

    localparam int             C17_WIDTH = 5;
    localparam logic [4:0]     C17_SEED  = 5'b00001;
    localparam logic [4:0]     C17_TAPS  = 5'b10100;

endpackage

// File: rtl/bist_lfsr.sv
// Fibonacci-style shift-left LFSR with load and step enables.
// Reset clears the state; a session always begins with a load of SEED.
module bist_lfsr #(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] SEED  = 5'b00001,
    parameter logic [WIDTH-1:0] TAPS  = 5'b10100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = SEED;
        end else if (step) begin
            state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/c17_bist_tpg.sv
// Test pattern generator for the c17 CUT: LFSR or exhaustive patterns offered
// over valid/ready, bounded by an IDLE/RUN/DONE session FSM.
module c17_bist_tpg
    import bist_pkg::*;
#(
    parameter int               WIDTH        = C17_WIDTH,
    parameter int               NUM_PATTERNS = 31,
    parameter logic [WIDTH-1:0] SEED         = C17_SEED,
    parameter logic [WIDTH-1:0] TAPS         = C17_TAPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    output logic [WIDTH-1:0] pat,
    output logic             pat_valid,
    input  logic             pat_ready,
    output logic [WIDTH:0]   pat_count,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH:0] LAST_LFSR = (WIDTH+1)'(NUM_PATTERNS - 1);
    localparam logic [WIDTH:0] LAST_EXH  = {1'b0, {WIDTH{1'b1}}};

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] exh_q, exh_d;
    logic [WIDTH:0]   count_q, count_d;
    logic [WIDTH:0]   last_count;
    logic             lfsr_load;
    logic             lfsr_step;
    logic [WIDTH-1:0] lfsr_state;

    bist_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (SEED),
        .TAPS  (TAPS)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .state (lfsr_state)
    );

    assign last_count = (mode_q == MODE_EXH) ? LAST_EXH : LAST_LFSR;

    // Abort wins over both start and an in-flight handshake.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        exh_d     = exh_q;
        count_d   = count_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d   = RUN;
                        mode_d    = mode;
                        count_d   = '0;
                        exh_d     = '0;
                        lfsr_load = 1'b1;
                    end
                end
                RUN: begin
                    if (pat_ready) begin
                        count_d = count_q + (WIDTH+1)'(1);
                        if (mode_q == MODE_EXH) begin
                            exh_d = exh_q + WIDTH'(1);
                        end else begin
                            lfsr_step = 1'b1;
                        end
                        if (count_q == last_count) begin
                            state_d = DONE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_LFSR;
            exh_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            exh_q   <= exh_d;
            count_q <= count_d;
        end
    end

    assign pat       = (mode_q == MODE_EXH) ? exh_q : lfsr_state;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign pat_valid = busy;
    assign pat_count = count_q;

endmodule

// File: tb/tb_c17_bist_tpg.sv
// Directed self-checking bench for c17_bist_tpg with hand-computed expectations.
module tb_c17_bist_tpg;

    logic       clk = 1'b0;
    logic       rst, start, mode, abort, pat_ready;
    logic [4:0] pat;
    logic       pat_valid;
    logic [5:0] pat_count;
    logic       busy, done;

    int vectors     = 0;
    int miscompares = 0;

    // First patterns of the LFSR sequence from SEED=1, TAPS=10100, worked by hand.
    logic [4:0] lfsr_table [7] = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05, 5'h0B};

    c17_bist_tpg dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .abort     (abort),
        .pat       (pat),
        .pat_valid (pat_valid),
        .pat_ready (pat_ready),
        .pat_count (pat_count),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] lfsrNext(input logic [4:0] s);
        return {s[3:0], s[4] ^ s[2]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic m, input logic a, input logic r);
        start     = s;
        mode      = m;
        abort     = a;
        pat_ready = r;
    endtask

    task automatic checkStatus(input string tag, input logic v, input logic b, input logic d, input logic [5:0] c);
        checkOutput({tag, ".valid"}, 32'(pat_valid), 32'(v));
        checkOutput({tag, ".busy"},  32'(busy),      32'(b));
        checkOutput({tag, ".done"},  32'(done),      32'(d));
        checkOutput({tag, ".count"}, 32'(pat_count), 32'(c));
    endtask

    initial begin
        logic [4:0] model;
        logic [4:0] expect_pat;
        logic       seen [32];
        int         distinct;

        // Reset and idle
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        checkStatus("reset", 1'b0, 1'b0, 1'b0, 6'd0);
        checkOutput("reset.pat", 32'(pat), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("idle.valid", 32'(pat_valid), 32'h0);
        end
        checkStatus("idle", 1'b0, 1'b0, 1'b0, 6'd0);

        // Full LFSR session with ready held high
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkStatus("lfsr.start", 1'b1, 1'b1, 1'b0, 6'd0);
        foreach (seen[k]) seen[k] = 1'b0;
        distinct = 0;
        model = 5'h01;
        for (int i = 0; i < 31; i++) begin
            expect_pat = (i < 7) ? lfsr_table[i] : model;
            checkOutput("lfsr.pat", 32'(pat), 32'(expect_pat));
            checkOutput("lfsr.valid", 32'(pat_valid), 32'h1);
            if (pat != 5'h0 && !seen[pat]) distinct++;
            seen[pat] = 1'b1;
            model = lfsrNext(expect_pat);
            tick();
        end
        checkOutput("lfsr.distinct", 32'(distinct), 32'd31);
        checkStatus("lfsr.done", 1'b0, 1'b0, 1'b1, 6'd31);
        tick();
        checkStatus("lfsr.hold", 1'b0, 1'b0, 1'b1, 6'd31);

        // Start in DONE launches an exhaustive session
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkStatus("exh.start", 1'b1, 1'b1, 1'b0, 6'd0);
        for (int i = 0; i < 32; i++) begin
            checkOutput("exh.pat", 32'(pat), 32'(i));
            tick();
        end
        checkStatus("exh.done", 1'b0, 1'b0, 1'b1, 6'd32);

        // Backpressure while pat=0x09, with a stray start that must be ignored
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("bp.seed", 32'(pat), 32'h01);
        tick();
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp.hold.pat", 32'(pat), 32'h09);
            checkOutput("bp.hold.valid", 32'(pat_valid), 32'h1);
            checkOutput("bp.hold.count", 32'(pat_count), 32'd3);
            if (i == 1) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            else        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("bp.still09", 32'(pat), 32'h09);
        tick();
        checkOutput("bp.next", 32'(pat), 32'h12);
        checkStatus("bp.next", 1'b1, 1'b1, 1'b0, 6'd4);

        // Abort after 4 transfers, with ready high so abort must beat the handshake
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkStatus("abort", 1'b0, 1'b0, 1'b0, 6'd4);
        tick();
        checkStatus("abort.idle", 1'b0, 1'b0, 1'b0, 6'd4);

        // Restart after abort
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("restart.pat", 32'(pat), 32'h01);
        checkStatus("restart", 1'b1, 1'b1, 1'b0, 6'd0);
        tick();
        checkOutput("restart.pat2", 32'(pat), 32'h02);

        // start and abort together in RUN go to IDLE
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkStatus("startabort", 1'b0, 1'b0, 1'b0, 6'd1);

        // Reset mid-session clears everything
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkStatus("midreset", 1'b0, 1'b0, 1'b0, 6'd0);
        checkOutput("midreset.pat", 32'(pat), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
